// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: segment patterns,
// digit positions and adjust-pair selectors.
package stopwatch_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low cathodes, bit0=a .. bit6=g
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000,
    7'b1111001,
    7'b0100100,
    7'b0110000,
    7'b0011001,
    7'b0010010,
    7'b0000010,
    7'b1111000,
    7'b0000000,
    7'b0010000
  };

  localparam logic [1:0] POS_SEC_BOT = 2'd0;
  localparam logic [1:0] POS_SEC_TOP = 2'd1;
  localparam logic [1:0] POS_MIN_BOT = 2'd2;
  localparam logic [1:0] POS_MIN_TOP = 2'd3;

  localparam logic ADJ_SEL_SEC = 1'b0;
  localparam logic ADJ_SEL_MIN = 1'b1;

  localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; codes above 9 show a dash.
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// Multiplexed 4-digit common-anode display driver with per-slot dead time,
// once-per-frame digit snapshot and adjust-mode pair blinking.
module display_scan
  import stopwatch_pkg::*;
#(
  parameter int SLOT_CYCLES       = 100_000,
  parameter int DEAD_CYCLES       = 1_000,
  parameter int BLINK_HALF_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] minutes_top_digit,
  input  logic [3:0] minutes_bot_digit,
  input  logic [3:0] seconds_top_digit,
  input  logic [3:0] seconds_bot_digit,
  input  logic       adj_en,
  input  logic       adj_sel,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int BW = (BLINK_HALF_CYCLES > 1) ? $clog2(BLINK_HALF_CYCLES) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] DEAD_END   = SW'(DEAD_CYCLES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYCLES - 1);

  logic [SW-1:0] slot_cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [3:0]    snapshot [4];

  logic       frame_start;
  logic       pair_sel;
  logic       blanked;
  logic [3:0] cur_digit;
  logic [6:0] cur_seg;

  assign frame_start = (slot_cnt == '0) && (idx == POS_SEC_BOT);
  assign pair_sel    = ((adj_sel == ADJ_SEL_MIN) && idx[1]) ||
                       ((adj_sel == ADJ_SEL_SEC) && !idx[1]);
  assign blanked     = (slot_cnt < DEAD_END) || (adj_en && blink_phase && pair_sel);
  assign cur_digit   = snapshot[idx];

  seg7_decode u_decode (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  // Scan counters, blink divider and the frame snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt    <= '0;
      idx         <= 2'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      for (int i = 0; i < 4; i++) snapshot[i] <= 4'd0;
    end else begin
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      // Leaving adjust mode parks the divider so re-entry starts visible
      if (!adj_en) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      if (frame_start) begin
        snapshot[POS_SEC_BOT] <= seconds_bot_digit;
        snapshot[POS_SEC_TOP] <= seconds_top_digit;
        snapshot[POS_MIN_BOT] <= minutes_bot_digit;
        snapshot[POS_MIN_TOP] <= minutes_top_digit;
      end
    end
  end

  // Registered pin drivers so anodes and cathodes switch on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_start;
      if (blanked) begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= cur_seg;
        dp  <= (idx == POS_MIN_BOT) ? 1'b0 : 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: stimulus pushes the expected pin state
// for every clock edge, a negedge monitor pops and compares.
module tb_display_scan;

  localparam int SLOT  = 8;
  localparam int DEAD  = 2;
  localparam int BLINK = 40;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mt, mb, st, sb;
  logic       adj_en, adj_sel;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_tick;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } exp_t;

  exp_t  expQ [$];
  string tagQ [$];
  int    checks = 0;
  int    errors = 0;

  int         framePos;
  int         adjAge;
  logic [3:0] snap [4];
  string      phaseName;

  display_scan #(
    .SLOT_CYCLES       (SLOT),
    .DEAD_CYCLES       (DEAD),
    .BLINK_HALF_CYCLES (BLINK)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .minutes_top_digit (mt),
    .minutes_bot_digit (mb),
    .seconds_top_digit (st),
    .seconds_bot_digit (sb),
    .adj_en            (adj_en),
    .adj_sel           (adj_sel),
    .seg               (seg),
    .dp                (dp),
    .an                (an),
    .frame_tick        (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] segOf(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic checkOutput(input exp_t e, input string tag);
    checks++;
    if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_tick !== e.ft) begin
      errors++;
      $display("[TB] FAIL %s: got an=%b seg=%b dp=%b ft=%b, want an=%b seg=%b dp=%b ft=%b",
               tag, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.ft);
    end
  endtask

  // Predict the pins after the coming edge, then advance the bench's view of the frame
  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      exp_t e;
      int   slot, pos;
      logic phase, blank;
      if (rst) begin
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.ft = 1'b0;
        framePos = 0;
        adjAge   = 0;
        for (int i = 0; i < 4; i++) snap[i] = 4'd0;
      end else begin
        slot  = framePos % SLOT;
        pos   = framePos / SLOT;
        phase = ((adjAge / BLINK) % 2) == 1;
        blank = (slot < DEAD) || (adj_en && phase && ((pos >= 2) == adj_sel));
        e.ft  = (framePos == 0);
        if (blank) begin
          e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
        end else begin
          e.an  = ~(4'(1) << pos);
          e.seg = segOf(snap[pos]);
          e.dp  = (pos == 2) ? 1'b0 : 1'b1;
        end
        if (framePos == 0) begin
          snap[0] = sb; snap[1] = st; snap[2] = mb; snap[3] = mt;
        end
        adjAge   = adj_en ? adjAge + 1 : 0;
        framePos = (framePos + 1) % FRAME;
      end
      expQ.push_back(e);
      tagQ.push_back($sformatf("%s@pos%0d", phaseName, framePos));
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t  e;
      string t;
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checkOutput(e, t);
    end
  end

  initial begin
    rst = 1'b1; mt = 4'd0; mb = 4'd0; st = 4'd0; sb = 4'd0;
    adj_en = 1'b0; adj_sel = 1'b0;
    framePos = 0; adjAge = 0;
    for (int i = 0; i < 4; i++) snap[i] = 4'd0;

    phaseName = "reset";
    applyStimulus(3);

    phaseName = "digits1234";
    mt = 4'd1; mb = 4'd2; st = 4'd3; sb = 4'd4;
    rst = 1'b0;
    applyStimulus(2 * FRAME);

    // Change the rightmost digit while its slot is on screen
    phaseName = "midframe";
    while (framePos != 4) applyStimulus(1);
    sb = 4'd7;
    applyStimulus(2 * FRAME);

    phaseName = "dash";
    sb = 4'hC;
    applyStimulus(FRAME + 8);

    phaseName = "blinkMin";
    sb = 4'd4;
    adj_en = 1'b1; adj_sel = 1'b1;
    applyStimulus(200);

    phaseName = "adjOff";
    adj_en = 1'b0;
    applyStimulus(40);

    phaseName = "blinkSec";
    adj_en = 1'b1; adj_sel = 1'b0;
    applyStimulus(100);
    adj_en = 1'b0;
    applyStimulus(16);

    // Reset lands in the active part of the position-2 slot
    phaseName = "midReset";
    while (framePos != 19) applyStimulus(1);
    rst = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    phaseName = "afterReset";
    applyStimulus(FRAME + 8);

    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, want 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
